fifo_reader: RTL and testbench

Pop-side controller for the `fifo` block. It tracks FIFO occupancy by observing the writer's `push` and its own `pop`, and drains words whenever any are stored. Drained words go through a 2-entry output skid buffer that presents them downstream with a valid/ready handshake. It sits between `fifo` and any consumer that can stall, and is the reading counterpart to the writer that drives `push`/`in`.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/skid_buf2.sv | 75 +++++++
 rtl/fifo_reader.sv | 66 ++++++
 tb/tb_fifo_reader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared parameters and types for the fifo block and its pop-side reader.
package fifo_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_WIDTH = 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry output skid buffer: head is always the word on out_data, tail
// holds the following word while the consumer stalls.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       state_dbg
);

  // Handshake: a word moves across a port in any cycle where that port's
  // valid and ready are both high; in_valid is only raised when in_ready is.
  skid_state_e      state_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic             valid_q;
  logic             take;

  assign take      = valid_q & out_ready;
  assign in_ready  = (state_q != S_TWO) | take;
  assign out_data  = head_q;
  assign out_valid = valid_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_valid) begin
            head_q  <= in_data;
            state_q <= S_ONE;
            valid_q <= 1'b1;
          end
        end
        S_ONE: begin
          if (in_valid && take) begin
            head_q <= in_data;
          end else if (in_valid) begin
            tail_q  <= in_data;
            state_q <= S_TWO;
          end else if (take) begin
            state_q <= S_EMPTY;
            valid_q <= 1'b0;
          end
        end
        S_TWO: begin
          // Leaving TWO is only possible on a take; tail shifts into head.
          if (take) begin
            head_q <= tail_q;
            if (in_valid) tail_q <= in_data;
            else          state_q <= S_ONE;
          end
        end
        default: begin
          state_q <= S_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Pop-side controller for fifo: mirrors occupancy from push/pop, drains
// stored words into a skid buffer and flags pushes attempted while full.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         full,
  input  logic [WIDTH-1:0]             fifo_out,
  output logic                         pop,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         ovf,
  output logic [1:0]                   state_dbg
);

  localparam int CW = $clog2(DEPTH+1);

  logic          wr;
  logic          in_ready;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  // full is the pre-pop flag, so a push at DEPTH is dropped even if we pop.
  assign wr  = push & ~full;
  assign pop = (count_q != '0) & in_ready;

  always_comb begin
    count_d = count_q + CW'(wr) - CW'(pop);
    ovf_d   = ovf_q | (push & full);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign ovf   = ovf_q;

  skid_buf2 #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (pop),
    .in_data   (fifo_out),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_dbg (state_dbg)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a queue-based fifo model feeds the DUT and a word
// scoreboard checks delivery order, occupancy, pop and ovf each cycle.
module tb_fifo_reader;

  localparam int DEPTH = 4;
  localparam int W     = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push;
  logic          full;
  logic [W-1:0]  fifo_out;
  logic          pop;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          empty;
  logic          ovf;
  logic [1:0]    state_dbg;

  fifo_reader #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .push      (push),
    .full      (full),
    .fifo_out  (fifo_out),
    .pop       (pop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .empty     (empty),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  logic [W-1:0] fifo_q[$];   // words stored in the fifo
  logic [W-1:0] bq[$];       // words popped into the reader, not yet taken
  logic [W-1:0] exp_q[$];    // accepted, not yet delivered words, in push order
  logic [W-1:0] dlog[$];     // delivered words (per phase)
  int           take_cyc[$];
  bit           ovf_m;
  int           cyc;
  int           pop_seen, valid_seen;
  int           n_checks, n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    fifo_q.delete(); bq.delete(); exp_q.delete();
    ovf_m = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check just after, update model at posedge.
  task automatic step(input logic push_v, input logic [W-1:0] data_v, input logic ready_v);
    logic exp_pop, take, wr_v;
    logic [W-1:0] w;
    @(negedge clk);
    push      = push_v;
    out_ready = ready_v;
    full      = (fifo_q.size() == DEPTH);
    fifo_out  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    exp_pop = (fifo_q.size() != 0) && ((bq.size() < 2) || ready_v);
    take    = (bq.size() != 0) && ready_v;
    check_eq("pop", 32'(pop), 32'(exp_pop));
    check_eq("count", 32'(count), 32'(fifo_q.size()));
    check_eq("empty", 32'(empty), 32'(fifo_q.size() == 0));
    check_eq("ovf", 32'(ovf), 32'(ovf_m));
    check_eq("out_valid", 32'(out_valid), 32'(bq.size() != 0));
    check_eq("state", 32'(state_dbg), 32'(bq.size()));
    if (bq.size() != 0) check_eq("out_data", 32'(out_data), 32'(bq[0]));
    if (pop)       pop_seen++;
    if (out_valid) valid_seen++;
    if (take) begin
      check_eq("word_available", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check_eq("order", 32'(out_data), 32'(w));
      end
      dlog.push_back(out_data);
      take_cyc.push_back(cyc);
    end
    wr_v = push_v && !full;
    @(posedge clk);
    if (push_v && full) ovf_m = 1'b1;
    if (take)    void'(bq.pop_front());
    if (exp_pop) bq.push_back(fifo_q.pop_front());
    if (wr_v) begin
      fifo_q.push_back(data_v);
      exp_q.push_back(data_v);
    end
    cyc++;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    check_eq("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  logic [W-1:0] stall_words[7] = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10, 2'b01};
  logic [W-1:0] stall_exp[6]   = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10};
  logic [W-1:0] stream_words[4] = '{2'b10, 2'b01, 2'b00, 2'b11};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [W-1:0] burst[$];
    n_checks = 0; n_fail = 0; cyc = 0;
    push = 1'b0; full = 1'b0; fifo_out = '0; out_ready = 1'b0;
    model_clear();

    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_eq("rst_pop", 32'(pop), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;

    // single word, consumer ready
    pop_seen = 0; valid_seen = 0; dlog.delete();
    step(1'b1, 2'b11, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1);
    check_eq("single_pops", 32'(pop_seen), 32'd1);
    check_eq("single_valid_cycles", 32'(valid_seen), 32'd1);
    check_eq("single_words", 32'(dlog.size()), 32'd1);

    // stalled consumer: two words drawn into the buffer, fifo fills, 7th dropped
    pop_seen = 0; dlog.delete();
    for (int i = 0; i < 7; i++) step(1'b1, stall_words[i], 1'b0);
    step(1'b0, '0, 1'b0);
    #1;
    check_eq("stall_pops", 32'(pop_seen), 32'd2);
    check_eq("stall_count", 32'(count), 32'(DEPTH));
    check_eq("stall_ovf", 32'(ovf), 32'd1);
    check_eq("stall_state", 32'(state_dbg), 32'd2);
    drain(20);
    check_eq("stall_drained", 32'(dlog.size()), 32'd6);
    for (int i = 0; i < 6 && i < dlog.size(); i++)
      check_eq("stall_word", 32'(dlog[i]), 32'(stall_exp[i]));

    // streaming
    dlog.delete(); take_cyc.delete();
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, stream_words[i], 1'b1);
      check_eq("stream_count_le1", 32'(fifo_q.size() <= 1 && count <= 1), 32'd1);
    end
    repeat (4) begin
      step(1'b0, '0, 1'b1);
      check_eq("stream_count_le1", 32'(count <= 1), 32'd1);
    end
    check_eq("stream_words", 32'(take_cyc.size()), 32'd4);
    for (int i = 0; i < 4 && i < take_cyc.size(); i++) begin
      check_eq("stream_cycle", 32'(take_cyc[i]), 32'(c0 + 2 + i));
      check_eq("stream_word", 32'(dlog[i]), 32'(stream_words[i]));
    end

    // ready toggling during an 8-word burst
    dlog.delete(); burst.delete();
    for (int i = 0; i < 8; i++) begin
      burst.push_back(W'($urandom_range(0, 3)));
      step(1'b1, burst[i], 1'(i % 2 == 0));
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, '0, 1'(i % 2));
    drain(20);
    check_eq("toggle_words", 32'(dlog.size()), 32'd8);
    for (int i = 0; i < 8 && i < dlog.size(); i++)
      check_eq("toggle_word", 32'(dlog[i]), 32'(burst[i]));

    // reset mid-burst in state TWO with count=3
    for (int i = 0; i < 5; i++) step(1'b1, W'($urandom_range(0, 3)), 1'b0);
    #1;
    check_eq("mid_state", 32'(state_dbg), 32'd2);
    check_eq("mid_count", 32'(count), 32'd3);
    @(negedge clk);
    push = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_count", 32'(count), 32'd0);
    check_eq("mid_rst_ovf", 32'(ovf), 32'd0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1'b0, '0, 1'b1);
    dlog.delete();
    step(1'b1, 2'b01, 1'b1);
    step(1'b1, 2'b10, 1'b1);
    drain(10);
    check_eq("post_rst_words", 32'(dlog.size()), 32'd2);

    // randomized traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
